imm_ext_arbiter: RTL
====================

IMM_EXT_ARBITER -- requirements
Module: imm_ext_arbiter

Interface
REQ-001 SHALL have parameter TAG_W, default 4, width of the per-request tag returned with the result.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports rq0_valid/rq1_valid, input, 1, requester 0 (decode) / requester 1 (branch-target unit) presents a request.
REQ-005 SHALL have ports rq0_ready/rq1_ready, output, 1, request accepted this cycle when valid&ready.
REQ-006 SHALL have ports rq0_imm26/rq1_imm26, input, 26, instruction bits [25:0].
REQ-007 SHALL have ports rq0_ctrl/rq1_ctrl, input, 3, immediate format select.
REQ-008 SHALL have ports rq0_tag/rq1_tag, input, TAG_W, opaque tag.
REQ-009 SHALL have ports rsp_valid (output, 1), rsp_ready (input, 1), rsp_imm64 (output, 64), rsp_src (output, 1, granted requester), rsp_tag (output, TAG_W), rsp_err (output, 1, illegal ctrl).

Function
REQ-010 SHALL decode ctrl: 000 zero-extend imm26[21:10]; 001 sign-extend imm26[20:12]; 010 sign-extend imm26[25:0]; 011 sign-extend imm26[23:5]; 100 zero-extend imm26[20:5] then shift left by imm26[22:21]*16, bits shifted beyond 63 discarded.
REQ-011 SHALL, for ctrl 101-111, produce rsp_imm64 = 0 and rsp_err = 1; rsp_err = 0 otherwise.
REQ-012 SHALL hold one result register; FSM states EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-013 SHALL drive ready to a requester only when it is granted and (state EMPTY or rsp_ready=1); ready is a function of current inputs and state, with no dependency on the requester's own ready.
REQ-014 SHALL grant with round-robin: single requester valid wins; both valid -> requester indicated by priority pointer wins.
REQ-015 SHALL toggle the priority pointer to the non-winner only on an accepted transfer when both were valid; otherwise keep it.
REQ-016 SHALL register the extended value, source, tag and error on accept; rsp_valid rises the cycle after accept (latency 1).
REQ-017 SHALL, in FULL with rsp_ready=1 and a new accept, replace the result in the same cycle and stay FULL (one result per cycle throughput).
REQ-018 SHALL, in FULL with rsp_ready=1 and no accept, go EMPTY; in FULL with rsp_ready=0, hold all rsp_* outputs stable.
REQ-019 SHALL never drop or duplicate a request; a valid request not accepted shall be re-presented by the requester unchanged.
REQ-020 SHALL deassert both ready outputs when neither requester is valid.

Reset
REQ-021 SHALL, on rst_n low, immediately force state EMPTY, rsp_valid=0, rsp_imm64=0, rsp_src=0, rsp_tag=0, rsp_err=0, priority pointer=0 (requester 0 first).
REQ-022 SHALL discard any held result when reset asserts mid-transfer; no response is issued for it after release.
REQ-023 SHALL accept requests from the first rising edge with rst_n high.

Structure
REQ-024 SHALL place the ctrl encodings (I, D, B, CB, MOVZ) as named 3-bit constants in the shared CPU package.
REQ-025 SHALL contain the combinational decode of REQ-010/011 in one sub-module, imm_ext_core, instantiated once after the grant mux.
REQ-026 SHALL keep the FSM, pointer and result register in imm_ext_arbiter.

Verification
REQ-027 SHALL cover: rq0 only, ctrl=000, imm26[21:10]=12'hFFF -> next cycle rsp_imm64=64'h0000_0000_0000_0FFF, rsp_src=0, rsp_err=0.
REQ-028 SHALL cover: rq1 only, ctrl=011, imm26[23:5]=19'h40000 -> rsp_imm64=64'hFFFF_FFFF_FFFC_0000, rsp_src=1.
REQ-029 SHALL cover: ctrl=100, imm26[22:21]=2'b11, imm26[20:5]=16'hBEEF -> rsp_imm64=64'hBEEF_0000_0000_0000; ctrl=110 -> rsp_imm64=0, rsp_err=1.
REQ-030 SHALL cover: both valid for 4 cycles, rsp_ready=1 -> grants 0,1,0,1 and one rsp_valid per cycle with matching tags.
REQ-031 SHALL cover: rsp_ready=0 for 3 cycles while FULL -> both ready=0, rsp_* stable; rsp_ready=1 -> held result consumed and pending request accepted same cycle.
REQ-032 SHALL cover: rst_n low while FULL -> rsp_valid=0 immediately; after release rq1 and rq0 both valid -> rq0 granted first.

Source files
------------

// File: rtl/imm_ext_arbiter_pkg.sv
// Shared CPU package: immediate-format select encodings and arbiter state constants.
package imm_ext_arbiter_pkg;

    typedef logic [2:0] ctrl_t;

    localparam ctrl_t CTRL_I    = 3'b000;  // zero-extend imm26[21:10]
    localparam ctrl_t CTRL_D    = 3'b001;  // sign-extend imm26[20:12]
    localparam ctrl_t CTRL_B    = 3'b010;  // sign-extend imm26[25:0]
    localparam ctrl_t CTRL_CB   = 3'b011;  // sign-extend imm26[23:5]
    localparam ctrl_t CTRL_MOVZ = 3'b100;  // imm26[20:5] placed at halfword imm26[22:21]

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

endpackage

// File: rtl/imm_ext_arbiter_if.sv
// Two requester channels and one response channel of the immediate-extension arbiter.
interface imm_ext_arbiter_if
    import imm_ext_arbiter_pkg::*;
#(
    parameter int TAG_W = 4
);
    logic             rq0_valid;
    logic             rq0_ready;
    logic [25:0]      rq0_imm26;
    ctrl_t            rq0_ctrl;
    logic [TAG_W-1:0] rq0_tag;

    logic             rq1_valid;
    logic             rq1_ready;
    logic [25:0]      rq1_imm26;
    ctrl_t            rq1_ctrl;
    logic [TAG_W-1:0] rq1_tag;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [63:0]      rsp_imm64;
    logic             rsp_src;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_err;

    modport master (
        output rq0_valid, rq0_imm26, rq0_ctrl, rq0_tag,
        output rq1_valid, rq1_imm26, rq1_ctrl, rq1_tag,
        input  rq0_ready, rq1_ready,
        output rsp_ready,
        input  rsp_valid, rsp_imm64, rsp_src, rsp_tag, rsp_err
    );

    modport slave (
        input  rq0_valid, rq0_imm26, rq0_ctrl, rq0_tag,
        input  rq1_valid, rq1_imm26, rq1_ctrl, rq1_tag,
        output rq0_ready, rq1_ready,
        input  rsp_ready,
        output rsp_valid, rsp_imm64, rsp_src, rsp_tag, rsp_err
    );

endinterface

// File: rtl/imm_ext_core.sv
// Combinational immediate extraction/extension from a 26-bit instruction field.
module imm_ext_core
    import imm_ext_arbiter_pkg::*;
(
    input  logic [25:0] imm26,
    input  ctrl_t       ctrl,
    output logic [63:0] imm64,
    output logic        err
);

    logic [63:0] movz_val;

    // MOVZ: each halfword lane is filled only when it is the selected shift position.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_movz_lane
            assign movz_val[gi*16 +: 16] = (imm26[22:21] == 2'(gi)) ? imm26[20:5] : 16'h0000;
        end
    endgenerate

    always_comb begin
        imm64 = 64'h0;
        err   = 1'b0;
        case (ctrl)
            CTRL_I:    imm64 = {52'h0, imm26[21:10]};
            CTRL_D:    imm64 = {{55{imm26[20]}}, imm26[20:12]};
            CTRL_B:    imm64 = {{38{imm26[25]}}, imm26[25:0]};
            CTRL_CB:   imm64 = {{45{imm26[23]}}, imm26[23:5]};
            CTRL_MOVZ: imm64 = movz_val;
            default:   err   = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_ext_arbiter.sv
// Round-robin arbiter between decode and branch-target requesters feeding one
// immediate extender, with a single registered result slot.
module imm_ext_arbiter
    import imm_ext_arbiter_pkg::*;
#(
    parameter int TAG_W = 4
)(
    input  logic               clk,
    input  logic               rst_n,
    imm_ext_arbiter_if.slave   bus
);

    logic [0:0]       state_reg, state_next;
    logic             ptr_reg, ptr_next;
    logic [63:0]      imm_reg;
    logic             src_reg;
    logic [TAG_W-1:0] tag_reg;
    logic             err_reg;

    logic             gnt0, gnt1, both_valid, can_load, accept;
    logic [25:0]      sel_imm26;
    ctrl_t            sel_ctrl;
    logic [TAG_W-1:0] sel_tag;
    logic [63:0]      ext_imm64;
    logic             ext_err;

    // Pointer names the requester that wins a tie; a lone valid requester always wins.
    assign both_valid = bus.rq0_valid & bus.rq1_valid;
    assign gnt0       = bus.rq0_valid & (~bus.rq1_valid | ~ptr_reg);
    assign gnt1       = bus.rq1_valid & (~bus.rq0_valid |  ptr_reg);
    assign can_load   = (state_reg == ST_EMPTY) | bus.rsp_ready;
    assign accept     = (gnt0 | gnt1) & can_load;

    assign bus.rq0_ready = gnt0 & can_load;
    assign bus.rq1_ready = gnt1 & can_load;

    assign sel_imm26 = gnt1 ? bus.rq1_imm26 : bus.rq0_imm26;
    assign sel_ctrl  = gnt1 ? bus.rq1_ctrl  : bus.rq0_ctrl;
    assign sel_tag   = gnt1 ? bus.rq1_tag   : bus.rq0_tag;

    imm_ext_core u_core (
        .imm26 (sel_imm26),
        .ctrl  (sel_ctrl),
        .imm64 (ext_imm64),
        .err   (ext_err)
    );

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        if (accept) begin
            state_next = ST_FULL;
            if (both_valid) begin
                ptr_next = ~gnt1;
            end
        end else if ((state_reg == ST_FULL) && bus.rsp_ready) begin
            state_next = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_EMPTY;
            ptr_reg   <= 1'b0;
            imm_reg   <= 64'h0;
            src_reg   <= 1'b0;
            tag_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            if (accept) begin
                imm_reg <= ext_imm64;
                src_reg <= gnt1;
                tag_reg <= sel_tag;
                err_reg <= ext_err;
            end
        end
    end

    assign bus.rsp_valid = (state_reg == ST_FULL);
    assign bus.rsp_imm64 = imm_reg;
    assign bus.rsp_src   = src_reg;
    assign bus.rsp_tag   = tag_reg;
    assign bus.rsp_err   = err_reg;

endmodule
